// File: rtl/fpu_issue.sv
// Issue/sequencing front-end for the combinational 16-bit FPU: one request in flight,
// operands held for LATENCY cycles per datapath, fma chained as multiply then add.
module fpu_issue #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic             req_fmt_i,
    input  logic [15:0]      req_a_i,
    input  logic [15:0]      req_b_i,
    input  logic [15:0]      req_c_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             fpu_inst_o,
    output logic [15:0]      fpu_add_a_o,
    output logic [15:0]      fpu_add_b_o,
    output logic [15:0]      fpu_mult_a_o,
    output logic [15:0]      fpu_mult_b_o,
    input  logic [15:0]      fpu_add_out_i,
    input  logic [15:0]      fpu_mult_out_i
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, RESP} state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_FMA = 2'd3;
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    state_t             state_reg, state_next;
    logic [2:0]         cnt_reg;
    logic [1:0]         op_reg;
    logic [15:0]        c_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [15:0]        result_reg;
    logic               inst_reg;
    logic [15:0]        add_a_reg, add_b_reg, mult_a_reg, mult_b_reg;
    logic               ready_reg;
    logic               accept;
    logic               settle_done;

    assign accept      = req_valid_i & ready_reg;
    assign settle_done = (cnt_reg == 3'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (req_op_i == OP_ADD || req_op_i == OP_SUB) ? ADD : MUL;
                end
            end
            MUL: begin
                if (settle_done) begin
                    state_next = (op_reg == OP_FMA) ? ADD : RESP;
                end
            end
            ADD: begin
                if (settle_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ready is registered so it stays low while reset is asserted and rises with IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_reg  <= 1'b0;
            cnt_reg    <= 3'd0;
            op_reg     <= 2'd0;
            c_reg      <= 16'd0;
            tag_reg    <= '0;
            result_reg <= 16'd0;
            inst_reg   <= 1'b0;
            add_a_reg  <= 16'd0;
            add_b_reg  <= 16'd0;
            mult_a_reg <= 16'd0;
            mult_b_reg <= 16'd0;
        end else begin
            ready_reg <= (state_next == IDLE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg  <= CNT_LOAD;
                        op_reg   <= req_op_i;
                        c_reg    <= req_c_i;
                        tag_reg  <= req_tag_i;
                        inst_reg <= req_fmt_i;
                        if (req_op_i == OP_ADD) begin
                            add_a_reg <= req_a_i;
                            add_b_reg <= req_b_i;
                        end else if (req_op_i == OP_SUB) begin
                            add_a_reg <= req_a_i;
                            add_b_reg <= {~req_b_i[15], req_b_i[14:0]};
                        end else begin
                            mult_a_reg <= req_a_i;
                            mult_b_reg <= req_b_i;
                        end
                    end
                end
                MUL: begin
                    if (settle_done) begin
                        if (op_reg == OP_FMA) begin
                            add_a_reg <= fpu_mult_out_i;
                            add_b_reg <= c_reg;
                            cnt_reg   <= CNT_LOAD;
                        end else begin
                            result_reg <= fpu_mult_out_i;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                ADD: begin
                    if (settle_done) begin
                        result_reg <= fpu_add_out_i;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o  = ready_reg;
    assign rsp_valid_o  = (state_reg == RESP);
    assign rsp_result_o = result_reg;
    assign rsp_tag_o    = tag_reg;
    assign fpu_inst_o   = inst_reg;
    assign fpu_add_a_o  = add_a_reg;
    assign fpu_add_b_o  = add_b_reg;
    assign fpu_mult_a_o = mult_a_reg;
    assign fpu_mult_b_o = mult_b_reg;

endmodule
